// File: rtl/cpu.sv
// Single-cycle MIPS32-subset integer core: register file, decoder and ALU.
// One R-type or I-type ALU instruction commits per rising clock edge.
module cpu #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     Inst,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [XLEN-1:0] alu_result,
    output logic            wr_en
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] B_RT   = 2'd0;
    localparam logic [1:0] B_SEXT = 2'd1;
    localparam logic [1:0] B_ZEXT = 2'd2;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = Inst[31:26];
    assign rs    = Inst[25:21];
    assign rt    = Inst[20:16];
    assign rd    = Inst[15:11];
    assign shamt = Inst[10:6];
    assign funct = Inst[5:0];
    assign imm   = Inst[15:0];

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    // $0 is never written, but the explicit guard keeps the zero register independent of the array.
    assign rs_val   = (rs == 5'd0)       ? '0 : regs_q[rs];
    assign rt_val   = (rt == 5'd0)       ? '0 : regs_q[rt];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

    logic [3:0] alu_sel;
    logic [1:0] b_sel;
    logic       shift_var;
    logic       dest_is_rd;
    logic       valid;

    always_comb begin
        // NOTE: every decode output gets a default first so no path can infer a latch.
        alu_sel    = ALU_ADD;
        b_sel      = B_RT;
        shift_var  = 1'b0;
        dest_is_rd = 1'b0;
        valid      = 1'b1;
        if (op == OP_RTYPE) begin
            dest_is_rd = 1'b1;
            unique case (funct)
                FN_ADD, FN_ADDU: alu_sel = ALU_ADD;
                FN_SUB, FN_SUBU: alu_sel = ALU_SUB;
                FN_AND:          alu_sel = ALU_AND;
                FN_OR:           alu_sel = ALU_OR;
                FN_XOR:          alu_sel = ALU_XOR;
                FN_NOR:          alu_sel = ALU_NOR;
                FN_SLT:          alu_sel = ALU_SLT;
                FN_SLTU:         alu_sel = ALU_SLTU;
                FN_SLL:          alu_sel = ALU_SLL;
                FN_SRL:          alu_sel = ALU_SRL;
                FN_SRA:          alu_sel = ALU_SRA;
                FN_SLLV: begin alu_sel = ALU_SLL; shift_var = 1'b1; end
                FN_SRLV: begin alu_sel = ALU_SRL; shift_var = 1'b1; end
                FN_SRAV: begin alu_sel = ALU_SRA; shift_var = 1'b1; end
                default:         valid   = 1'b0;
            endcase
        end else begin
            unique case (op)
                OP_ADDI, OP_ADDIU: begin alu_sel = ALU_ADD;  b_sel = B_SEXT; end
                OP_SLTI:           begin alu_sel = ALU_SLT;  b_sel = B_SEXT; end
                OP_SLTIU:          begin alu_sel = ALU_SLTU; b_sel = B_SEXT; end
                OP_ANDI:           begin alu_sel = ALU_AND;  b_sel = B_ZEXT; end
                OP_ORI:            begin alu_sel = ALU_OR;   b_sel = B_ZEXT; end
                OP_XORI:           begin alu_sel = ALU_XOR;  b_sel = B_ZEXT; end
                OP_LUI:            begin alu_sel = ALU_LUI;  b_sel = B_ZEXT; end
                default:           valid = 1'b0;
            endcase
        end
    end

    logic [XLEN-1:0] op_b;
    logic [4:0]      sh_amt;
    logic [XLEN-1:0] alu_out;
    logic [4:0]      dest;

    always_comb begin
        unique case (b_sel)
            B_SEXT:  op_b = {{(XLEN-16){imm[15]}}, imm};
            B_ZEXT:  op_b = {{(XLEN-16){1'b0}}, imm};
            default: op_b = rt_val;
        endcase
    end

    assign sh_amt = shift_var ? rs_val[4:0] : shamt;
    assign dest   = dest_is_rd ? rd : rt;

    // Adds and subtracts wrap silently; overflow never traps.
    always_comb begin
        unique case (alu_sel)
            ALU_ADD:  alu_out = rs_val + op_b;
            ALU_SUB:  alu_out = rs_val - op_b;
            ALU_AND:  alu_out = rs_val & op_b;
            ALU_OR:   alu_out = rs_val | op_b;
            ALU_XOR:  alu_out = rs_val ^ op_b;
            ALU_NOR:  alu_out = ~(rs_val | op_b);
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(rs_val) < $signed(op_b))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (rs_val < op_b)};
            ALU_SLL:  alu_out = op_b << sh_amt;
            ALU_SRL:  alu_out = op_b >> sh_amt;
            ALU_SRA:  alu_out = $signed(op_b) >>> sh_amt;
            ALU_LUI:  alu_out = {op_b[15:0], 16'h0000};
            default:  alu_out = '0;
        endcase
    end

    assign alu_result = valid ? alu_out : '0;
    assign wr_en      = valid;

    // NOTE: the register array sits on the async reset so rst_n clears every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (dest != 5'd0)) begin
            // NOTE: non-blocking so same-cycle reads still see the old value.
            regs_q[dest] <= alu_out;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed cases from the test plan, then random
// instruction streams compared against an instruction-level reference model.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Inst;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] alu_result;
    logic        wr_en;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q [32];
    logic [5:0]  r_functs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0]  bad_ops  [6]  = '{6'h02, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};
    logic [15:0] edge_imm [4]  = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

    always #5 clk = ~clk;

    cpu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Inst       (Inst),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .alu_result (alu_result),
        .wr_en      (wr_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_inst(input logic [5:0] fn, input logic [4:0] s,
                                           input logic [4:0] t, input logic [4:0] d,
                                           input logic [4:0] sh);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] o, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    // Reference semantics straight from the instruction set rules.
    function automatic void model(input logic [31:0] inst, output logic we,
                                  output logic [4:0] dst, output logic [31:0] res);
        logic [31:0] a, b, si, zi;
        logic [4:0]  sh;
        a   = model_q[inst[25:21]];
        b   = model_q[inst[20:16]];
        si  = {{16{inst[15]}}, inst[15:0]};
        zi  = {16'h0000, inst[15:0]};
        sh  = inst[10:6];
        we  = 1'b1;
        res = 32'h0;
        if (inst[31:26] == 6'h00) begin
            dst = inst[15:11];
            case (inst[5:0])
                6'h20, 6'h21: res = a + b;
                6'h22, 6'h23: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                6'h00: res = b << sh;
                6'h02: res = b >> sh;
                6'h03: res = 32'(int'(b) >>> sh);
                6'h04: res = b << a[4:0];
                6'h06: res = b >> a[4:0];
                6'h07: res = 32'(int'(b) >>> a[4:0]);
                default: we = 1'b0;
            endcase
        end else begin
            dst = inst[20:16];
            case (inst[31:26])
                6'h08, 6'h09: res = a + si;
                6'h0A: res = (int'(a) < int'(si)) ? 32'd1 : 32'd0;
                6'h0B: res = (a < si) ? 32'd1 : 32'd0;
                6'h0C: res = a & zi;
                6'h0D: res = a | zi;
                6'h0E: res = a ^ zi;
                6'h0F: res = {inst[15:0], 16'h0000};
                default: we = 1'b0;
            endcase
        end
        if (!we) res = 32'h0;
    endfunction

    // Drive one instruction on the falling edge, check combinational outputs,
    // commit at the rising edge, then read back the destination.
    task automatic step(input logic [31:0] inst, input string tag);
        logic        we;
        logic [4:0]  dst;
        logic [31:0] res;
        @(negedge clk);
        Inst = inst;
        #1;
        model(inst, we, dst, res);
        check({tag, "/alu"}, alu_result, res);
        if (!we || dst != 5'd0) check({tag, "/wr_en"}, {31'b0, wr_en}, {31'b0, we});
        @(posedge clk);
        if (we && dst != 5'd0) model_q[dst] = res;
        #1;
        dbg_addr = dst;
        #1;
        check({tag, "/rd"}, dbg_data, model_q[dst]);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Full register sweep with an unsupported instruction parked on Inst.
    task automatic sweep(input string tag);
        Inst = 32'hFC00_0000;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("%s/r%0d", tag, i), dbg_data, model_q[i]);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        int          c;
        logic [4:0]  s, t, d;
        logic [15:0] im;
        c  = $urandom_range(0, 99);
        s  = 5'($urandom_range(0, 7));
        t  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        im = ($urandom_range(0, 3) == 0) ? edge_imm[$urandom_range(0, 3)] : 16'($urandom);
        if (c < 55) return r_inst(r_functs[$urandom_range(0, 15)], s, t, d, 5'($urandom));
        if (c < 93) return i_inst(6'($urandom_range(8, 15)), s, t, im);
        if (c < 96) return i_inst(bad_ops[$urandom_range(0, 5)], s, t, im);
        if (c < 98) return r_inst(($urandom_range(0, 1) == 0) ? 6'h08 : 6'h18, s, t, d, 5'd0);
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model_q[i] = 32'h0;
        rst_n    = 1'b0;
        Inst     = 32'hFC00_0000;
        dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rd(5'd1, 32'h0, "reset_r1");
        rd(5'd31, 32'h0, "reset_r31");
        @(negedge clk);
        rst_n = 1'b1;

        step(32'h0000_0820, "add_r1_zero");
        rd(5'd1, 32'h0, "r1_zero");
        step(32'h2001_0001, "addi_r1_1");
        rd(5'd1, 32'h1, "r1_is_1");
        step(32'h0021_0820, "add_r1_r1");
        rd(5'd1, 32'h2, "r1_is_2");
        step(32'h0021_0820, "hold_add");
        rd(5'd1, 32'h4, "r1_is_4");

        step(32'h2002_FFFF, "addi_r2_m1");
        rd(5'd2, 32'hFFFF_FFFF, "r2_m1");
        step(r_inst(6'h2A, 5'd2, 5'd0, 5'd3, 5'd0), "slt");
        rd(5'd3, 32'h1, "slt_r3");
        step(r_inst(6'h2B, 5'd2, 5'd0, 5'd3, 5'd0), "sltu");
        rd(5'd3, 32'h0, "sltu_r3");
        step(r_inst(6'h03, 5'd0, 5'd2, 5'd4, 5'd4), "sra");
        rd(5'd4, 32'hFFFF_FFFF, "sra_r4");
        step(r_inst(6'h02, 5'd0, 5'd2, 5'd4, 5'd4), "srl");
        rd(5'd4, 32'h0FFF_FFFF, "srl_r4");

        step(i_inst(6'h0F, 5'd0, 5'd5, 16'h8000), "lui");
        step(i_inst(6'h0D, 5'd5, 5'd5, 16'h1234), "ori");
        rd(5'd5, 32'h8000_1234, "lui_ori_r5");
        step(i_inst(6'h0F, 5'd0, 5'd6, 16'h7FFF), "lui_7fff");
        step(i_inst(6'h0D, 5'd6, 5'd6, 16'hFFFF), "ori_ffff");
        step(i_inst(6'h08, 5'd0, 5'd7, 16'h0001), "addi_r7");
        step(r_inst(6'h20, 5'd6, 5'd7, 5'd8, 5'd0), "add_ovf");
        rd(5'd8, 32'h8000_0000, "ovf_r8");

        step(i_inst(6'h08, 5'd0, 5'd0, 16'h0005), "addi_r0");
        rd(5'd0, 32'h0, "r0_zero");
        step(32'hFC00_0000, "bad_op");
        check("bad_op/wr_en_low", {31'b0, wr_en}, 32'h0);
        sweep("after_bad");

        step(i_inst(6'h08, 5'd0, 5'd1, 16'h0002), "addi_r1_2");
        rd(5'd1, 32'h2, "pre_reset_r1");
        Inst = i_inst(6'h08, 5'd0, 5'd1, 16'h0007);
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model_q[i] = 32'h0;
        rd(5'd1, 32'h0, "async_clear_r1");
        @(posedge clk);
        #1;
        rd(5'd1, 32'h0, "no_write_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h2001_0001, "resume_addi");
        rd(5'd1, 32'h1, "resume_r1");

        for (int n = 0; n < 400; n++) begin
            step(rand_inst(), $sformatf("rand%0d", n));
        end
        @(negedge clk);
        sweep("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Single-cycle MIPS32-subset integer execution core; the instruction word is supplied externally each cycle via `Inst`.
- No fetch, PC or data memory. Contains a 32x32 register file, decoder and ALU.
- Executes one R-type or I-type ALU instruction per rising clock edge.
- Sits under an external instruction sequencer/fetch unit; exposes a debug read port for verification.

Parameters:
- NREGS, 32, number of architectural registers (5-bit specifiers; fixed at 32).
- XLEN, 32, datapath width.

Ports:
- clk  input  1  system clock; state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Inst  input  32  instruction to execute; must be stable before the rising edge (driven on the falling edge by the sequencer).
- dbg_addr  input  5  debug register-read address.
- dbg_data  output  32  combinational read of register dbg_addr (0 when dbg_addr=0).
- alu_result  output  32  combinational ALU result for the current Inst.
- wr_en  output  1  high when the current Inst will write the register file at the next rising edge.

Behaviour:
- Reset: rst_n low clears all registers to 0 immediately, independent of clk. While low, no writes occur. Outputs follow from the cleared state (dbg_data=0).
- Fields: op=Inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- Register $0 always reads 0; writes to $0 are discarded (wr_en may be high, no effect).
- Reads are combinational. Reading a register written in the same cycle returns the old value; the new value is visible after the edge.
- Latency: result committed at the first rising edge with Inst stable. One instruction per cycle, no stalls. Holding Inst constant re-executes it every edge.
- R-type (op=000000), destination rd:
  - add 100000 / addu 100001: rs+rt.
  - sub 100010 / subu 100011: rs-rt.
  - and 100100, or 100101, xor 100110, nor 100111.
  - slt 101010: signed less-than, result 1/0. sltu 101011: unsigned less-than, result 1/0.
  - sll 000000: rt<<shamt. srl 000010: logical rt>>shamt. sra 000011: arithmetic rt>>shamt.
  - sllv 000100, srlv 000110, srav 000111: shift rt by rs[4:0].
- I-type, destination rt:
  - Sign-extended imm: addi 001000, addiu 001001, slti 001010, sltiu 001011 (compares as unsigned after sign-extension).
  - Zero-extended imm: andi 001100, ori 001101, xori 001110.
  - lui 001111: {imm,16'h0}.
- Arithmetic: all adds/subs wrap modulo 2^32. Overflow is ignored: no trap, and the result is still written.
- Unsupported op/funct (incl. all-ones and branch/memory opcodes): wr_en=0, no state change, alu_result=0.
- Inst containing X/Z is treated as don't-care; the bench shall not drive X at a rising edge.
- rst_n asserted mid-sequence: registers cleared at once. Execution resumes at the first rising edge after rst_n deasserts.

Test Plan:
- Reset then add $1,$0,$0 (0x00000820), one edge -> dbg_addr=1 gives dbg_data=0x00000000.
- addi $1,$0,1 (0x20010001), one edge -> $1=0x00000001; then add $1,$1,$1 (0x00210820) one edge -> $1=0x00000002; hold Inst one more edge -> $1=0x00000004.
- addi $2,$0,-1 (0x2002FFFF) -> $2=0xFFFFFFFF; slt $3,$2,$0 -> $3=1; sltu $3,$2,$0 -> $3=0; sra $4,$2,4 -> $4=0xFFFFFFFF; srl $4,$2,4 -> $4=0x0FFFFFFF.
- lui $5,0x8000 then ori $5,$5,0x1234 -> $5=0x80001234; add with 0x7FFFFFFF+1 -> 0x80000000 written, no trap.
- addi $0,$0,5 -> dbg_addr=0 reads 0; unsupported opcode 0xFC000000 -> wr_en=0, all registers unchanged.
- Write $1=2, pull rst_n low between edges (clk static) -> $1 reads 0 immediately; release, addi $1,$0,1 -> $1=1.
